// File: rtl/sdr_msoc_cpu_debug_ocimem_pkg.sv
// sdr_msoc_cpu_debug_ocimem_pkg: shared types and jdo field positions for the debug OCI memory
package sdr_msoc_cpu_debug_ocimem_pkg;
    localparam int RAM_DEPTH   = 256;
    localparam int JDO_ADDR_HI = 33;
    localparam int JDO_ADDR_LO = 26;
    localparam int JDO_RDEN    = 35;
    localparam int JDO_DATA_HI = 34;
    localparam int JDO_DATA_LO = 3;
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} av_state_t;
endpackage

// File: rtl/sdr_msoc_cpu_debug_ocimem_if.sv
// sdr_msoc_cpu_debug_ocimem_if: Avalon debug slave port; address MSB selects the register window
interface sdr_msoc_cpu_debug_ocimem_if
    import sdr_msoc_cpu_debug_ocimem_pkg::*;
#(parameter int ADDR_W = $clog2(RAM_DEPTH), parameter int DATA_W = 32);
    logic [ADDR_W:0]       address;
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W/8-1:0]   byteenable;
    logic                  debugaccess;
    logic [DATA_W-1:0]     readdata;
    logic                  waitrequest;
    modport master (output address, chipselect, read, write, writedata, byteenable, debugaccess,
                    input readdata, waitrequest);
    modport slave  (input address, chipselect, read, write, writedata, byteenable, debugaccess,
                    output readdata, waitrequest);
endinterface

// File: rtl/sdr_msoc_cpu_debug_ocimem_ram.sv
// sdr_msoc_cpu_debug_ocimem_ram: single-port synchronous RAM with byte enables
// OCIMEM_PARITY_EN adds one even-parity bit per byte and a check on every explicit read
module sdr_msoc_cpu_debug_ocimem_ram
    import sdr_msoc_cpu_debug_ocimem_pkg::*;
#(parameter int ADDR_W = $clog2(RAM_DEPTH), parameter int DATA_W = 32) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                we,
    input  logic                re,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   q,
    output logic                perr
);
    localparam int NB = DATA_W / 8;
`ifdef OCIMEM_PARITY_EN
    logic [DATA_W+NB-1:0] mem [2**ADDR_W];
    logic [DATA_W+NB-1:0] q_raw;
    logic [NB-1:0]        par_bad;
    logic                 re_d;
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++)
            if (we && be[i]) begin
                mem[addr][8*i +: 8]  <= wdata[8*i +: 8];
                mem[addr][DATA_W+i]  <= ^wdata[8*i +: 8];
            end
        q_raw <= mem[addr];
    end
    // only explicit reads are checked so idle address churn over unwritten words stays silent
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) re_d <= 1'b0;
        else          re_d <= re;
    always_comb begin
        par_bad = '0;
        for (int i = 0; i < NB; i++) par_bad[i] = ^q_raw[8*i +: 8] ^ q_raw[DATA_W+i];
    end
    assign q    = q_raw[DATA_W-1:0];
    assign perr = re_d & |par_bad;
`else
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic              unused_ok;
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++)
            if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        q <= mem[addr];
    end
    assign perr      = 1'b0;
    assign unused_ok = reset_n ^ re;
`endif
endmodule

// File: rtl/sdr_msoc_cpu_debug_ocimem.sv
// sdr_msoc_cpu_debug_ocimem: debug monitor RAM shared by JTAG (priority) and the Avalon debug slave
// OCIMEM_PARITY_EN enables per-byte RAM parity and the sticky parity_err flag
module sdr_msoc_cpu_debug_ocimem
    import sdr_msoc_cpu_debug_ocimem_pkg::*;
#(parameter int ADDR_W = $clog2(RAM_DEPTH), parameter int DATA_W = 32) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [37:0]          jdo,
    input  logic                 take_action_ocimem_a,
    input  logic                 take_action_ocimem_b,
    input  logic                 take_no_action_ocimem_a,
    output logic [DATA_W-1:0]    MonDReg,
    sdr_msoc_cpu_debug_ocimem_if.slave av,
    input  logic [DATA_W-1:0]    reg_readdata,
    output logic                 reg_write,
    output logic                 parity_err
);
    av_state_t           state, state_nx;
    logic                jb, ja, jn, jrd, jrd_d, pend;
    logic                av_req, av_go, av_ram, acc_rd, acc_reg;
    logic                ram_we, ram_re, perr, unused_jdo;
    logic [ADDR_W-1:0]   mon_areg, jaddr, ram_addr;
    logic [DATA_W-1:0]   jdata, pend_data, q;
    logic [DATA_W/8-1:0] ram_be;

    assign jb       = take_action_ocimem_b;
    assign ja       = take_action_ocimem_a & ~jb;
    assign jn       = take_no_action_ocimem_a & ~take_action_ocimem_a & ~jb;
    assign jrd      = (ja & jdo[JDO_RDEN]) | jn;
    assign jaddr    = jdo[JDO_ADDR_HI:JDO_ADDR_LO];
    assign jdata    = jdo[JDO_DATA_HI:JDO_DATA_LO];
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign av_req   = av.chipselect & (av.read | av.write);
    assign av_go    = (state == IDLE) & av_req & ~(take_action_ocimem_a | jb | take_no_action_ocimem_a);
    assign av_ram   = ~av.address[ADDR_W];
    assign ram_addr = ja ? jaddr : (jb | jn) ? mon_areg : av.address[ADDR_W-1:0];
    assign ram_we   = jb | (av_go & av.write & av_ram & av.debugaccess);
    assign ram_re   = jrd | (av_go & ~av.write & av_ram);
    assign ram_be   = jb ? '1 : av.byteenable;
    assign reg_write = reset_n & av_go & av.write & ~av_ram;
    assign av.waitrequest = av_req & (state != ACK);

    sdr_msoc_cpu_debug_ocimem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
        .clk(clk), .reset_n(reset_n), .addr(ram_addr), .we(ram_we), .re(ram_re),
        .be(ram_be), .wdata(jb ? jdata : av.writedata), .q(q), .perr(perr)
    );

    always_comb state_nx = (state == ACCESS) ? ACK : (state == ACK) ? IDLE : av_go ? ACCESS : IDLE;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state       <= IDLE;
            mon_areg    <= '0;
            MonDReg     <= '0;
            jrd_d       <= 1'b0;
            pend        <= 1'b0;
            pend_data   <= '0;
            acc_rd      <= 1'b0;
            acc_reg     <= 1'b0;
            av.readdata <= '0;
            parity_err  <= 1'b0;
        end else begin
            state <= state_nx;
            jrd_d <= jrd;
            if (ja) mon_areg <= jaddr;
            else if (jb | jn) mon_areg <= mon_areg + 1'b1;
            // a write-data strobe landing on a read capture is deferred one cycle
            pend <= ((pend | jb) & jrd_d) | (pend & jb);
            if (jb) pend_data <= jdata;
            if (jrd_d) MonDReg <= q;
            else if (pend) MonDReg <= pend_data;
            else if (jb) MonDReg <= jdata;
            if (av_go) begin
                acc_rd  <= ~av.write;
                acc_reg <= ~av_ram;
            end
            if (state == ACCESS && acc_rd) av.readdata <= acc_reg ? reg_readdata : q;
            if (perr) parity_err <= 1'b1;
        end
endmodule

// File: tb/tb_sdr_msoc_cpu_debug_ocimem.sv
// tb_sdr_msoc_cpu_debug_ocimem: directed bench with a transaction-level model checked every cycle
// OCIMEM_PARITY_EN additionally exercises the sticky parity error
module tb_sdr_msoc_cpu_debug_ocimem;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        ta_a = 1'b0, ta_b = 1'b0, tn_a = 1'b0;
    logic [31:0] mondreg;
    logic [31:0] reg_readdata = 32'hCAFE0105;
    logic        reg_write, parity_err;

    sdr_msoc_cpu_debug_ocimem_if av();

    sdr_msoc_cpu_debug_ocimem dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b), .take_no_action_ocimem_a(tn_a),
        .MonDReg(mondreg), .av(av), .reg_readdata(reg_readdata),
        .reg_write(reg_write), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_m [256];
    logic [7:0]  mona_m = '0;
    logic [31:0] exp_mon = '0, exp_rd = '0;
    logic        exp_wait = 1'b0, exp_regw = 1'b0, exp_perr = 1'b0;
    int          checks = 0, errors = 0, regw_count = 0, regw_base;
    bit          chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, want, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("MonDReg", mondreg, exp_mon);
        chk("readdata", av.readdata, exp_rd);
        chk("waitrequest", 32'(av.waitrequest), 32'(exp_wait));
        chk("reg_write", 32'(reg_write), 32'(exp_regw));
        chk("parity_err", 32'(parity_err), 32'(exp_perr));
        chk("MonAReg", 32'(dut.mon_areg), 32'(mona_m));
        if (reg_write) regw_count++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic jt_a(input logic [7:0] a, input logic rden);
        jdo = '0; jdo[35] = rden; jdo[33:26] = a; ta_a = 1'b1;
        cyc(); ta_a = 1'b0; mona_m = a;
        if (rden) begin cyc(); exp_mon = mem_m[a]; end
    endtask

    task automatic jt_b(input logic [31:0] d);
        jdo = '0; jdo[34:3] = d; ta_b = 1'b1;
        cyc(); ta_b = 1'b0;
        mem_m[mona_m] = d; exp_mon = d; mona_m++;
    endtask

    task automatic jt_n();
        logic [7:0] a;
        tn_a = 1'b1;
        cyc(); tn_a = 1'b0;
        a = mona_m; mona_m++;
        cyc(); exp_mon = mem_m[a];
    endtask

    task automatic av_rd(input logic [8:0] a);
        av.address = a; av.chipselect = 1'b1; av.read = 1'b1; av.write = 1'b0; exp_wait = 1'b1;
        cyc(); cyc();
        exp_rd = a[8] ? reg_readdata : mem_m[a[7:0]]; exp_wait = 1'b0;
        cyc(); av.chipselect = 1'b0; av.read = 1'b0;
    endtask

    task automatic av_wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be, input logic dbg);
        av.address = a; av.writedata = d; av.byteenable = be; av.debugaccess = dbg;
        av.chipselect = 1'b1; av.write = 1'b1; av.read = 1'b0; exp_wait = 1'b1; exp_regw = a[8];
        cyc(); exp_regw = 1'b0;
        if (!a[8] && dbg) for (int i = 0; i < 4; i++) if (be[i]) mem_m[a[7:0]][8*i +: 8] = d[8*i +: 8];
        cyc(); exp_wait = 1'b0;
        cyc(); av.chipselect = 1'b0; av.write = 1'b0;
    endtask

    initial begin
        av.address = '0; av.chipselect = 1'b0; av.read = 1'b0; av.write = 1'b0;
        av.writedata = '0; av.byteenable = '0; av.debugaccess = 1'b0;
        chk_en = 1'b1;
        repeat (2) cyc();
        reset_n = 1'b1;
        jt_a(8'hFF, 1'b0); jt_b(32'h11111111); jt_b(32'h22222222);
        jt_a(8'h20, 1'b0); jt_b(32'hAAAA5555);
        jt_a(8'h10, 1'b0); jt_b(32'hDEADBEEF); jt_a(8'h10, 1'b1);
        chk("lit_jtag_readback", mondreg, 32'hDEADBEEF);
        chk("lit_monareg", 32'(dut.mon_areg), 32'h10);
        jt_a(8'hFF, 1'b0);
        jt_n(); chk("lit_stream_ff", mondreg, 32'h11111111);
        jt_n(); chk("lit_stream_00", mondreg, 32'h22222222);
        chk("lit_stream_wrap", 32'(dut.mon_areg), 32'h01);
        av_rd(9'h010); chk("lit_av_read", av.readdata, 32'hDEADBEEF);
        av_wr(9'h020, 32'h12345678, 4'hF, 1'b0);
        av_rd(9'h020); chk("lit_wprot", av.readdata, 32'hAAAA5555);
        av_wr(9'h020, 32'h12345678, 4'h3, 1'b1);
        av_rd(9'h020); chk("lit_byteen", av.readdata, 32'hAAAA5678);
        jt_a(8'h40, 1'b0);
        av.address = 9'h105; av.writedata = 32'h0BADF00D; av.byteenable = 4'hF; av.debugaccess = 1'b1;
        av.chipselect = 1'b1; av.write = 1'b1; exp_wait = 1'b1; exp_regw = 1'b0;
        regw_base = regw_count;
        jt_b(32'h13572468);
        exp_regw = 1'b1;
        cyc(); exp_regw = 1'b0;
        cyc(); exp_wait = 1'b0;
        cyc(); av.chipselect = 1'b0; av.write = 1'b0;
        chk("lit_regw_pulses", 32'(regw_count - regw_base), 32'd1);
        jt_a(8'h40, 1'b1); chk("lit_jtag_first", mondreg, 32'h13572468);
        av_rd(9'h105); chk("lit_reg_read", av.readdata, 32'hCAFE0105);
        jdo = '0; jdo[35] = 1'b1; jdo[33:26] = 8'h10; ta_a = 1'b1;
        cyc(); ta_a = 1'b0; mona_m = 8'h10;
        jdo = '0; jdo[34:3] = 32'h600DCAFE; ta_b = 1'b1;
        cyc(); ta_b = 1'b0;
        exp_mon = mem_m[8'h10]; mem_m[8'h10] = 32'h600DCAFE; mona_m = 8'h11;
        chk("lit_capture_kept", mondreg, 32'hDEADBEEF);
        cyc(); exp_mon = 32'h600DCAFE;
        chk("lit_deferred_b", mondreg, 32'h600DCAFE);
        av.address = 9'h010; av.chipselect = 1'b1; av.read = 1'b1; exp_wait = 1'b1;
        cyc();
        reset_n = 1'b0; exp_mon = '0; exp_rd = '0; mona_m = '0;
        repeat (2) cyc();
        av.chipselect = 1'b0; av.read = 1'b0; exp_wait = 1'b0;
        cyc(); reset_n = 1'b1;
        cyc();
`ifdef OCIMEM_PARITY_EN
        jt_a(8'h30, 1'b0); jt_b(32'h0F0F0F0F);
        dut.u_ram.mem[8'h30][0] = ~dut.u_ram.mem[8'h30][0];
        mem_m[8'h30] = 32'h0F0F0F0E;
        jt_a(8'h30, 1'b1); exp_perr = 1'b1;
        chk("lit_parity_data", mondreg, 32'h0F0F0F0E);
        repeat (3) cyc();
        chk("lit_parity_sticky", 32'(parity_err), 32'd1);
        reset_n = 1'b0; exp_perr = 1'b0; exp_mon = '0; exp_rd = '0; mona_m = '0;
        cyc(); reset_n = 1'b1;
        cyc();
`endif
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdr_msoc_cpu_debug_ocimem.md
Name: sdr_msoc_cpu_debug_ocimem

Overview:
Debug on-chip memory stage directly downstream of the CPU debug-slave JTAG wrapper. Consumes the wrapper's jdo word and take_action_ocimem_a / take_action_ocimem_b / take_no_action_ocimem_a strobes to read and write a 256x32 debug monitor RAM. Returns read data to the wrapper through MonDReg. Also serves the CPU's Avalon debug slave port: RAM in the lower half of the address space, register window in the upper half. JTAG accesses take priority over Avalon accesses.

Parameters:
ADDR_W, 8, RAM word-address width (depth 2**ADDR_W)
DATA_W, 32, data width; all field positions below assume 32

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
jdo  in  38  JTAG data word from debug slave (sysclk domain)
take_action_ocimem_a  in  1  JTAG address/read command pulse
take_action_ocimem_b  in  1  JTAG write-data command pulse
take_no_action_ocimem_a  in  1  JTAG stream-read (auto-increment) pulse
MonDReg  out  32  JTAG monitor data register, returned to debug slave
address  in  9  Avalon word address; [8]=1 selects register window
chipselect  in  1  Avalon select
read  in  1  Avalon read
write  in  1  Avalon write
writedata  in  32  Avalon write data
byteenable  in  4  Avalon byte enables
debugaccess  in  1  write to RAM permitted only when 1
readdata  out  32  Avalon read data (registered)
waitrequest  out  1  Avalon stall
reg_readdata  in  32  register-window read data
reg_write  out  1  one-cycle register-window write strobe (address[7:0], writedata passed through)
parity_err  out  1  sticky parity error (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0):
  - MonDReg, MonAReg (internal 8-bit), readdata, reg_write, parity_err = 0.
  - Avalon FSM = IDLE. RAM contents undefined.
- RAM: synchronous; address in cycle n, q valid in cycle n+1. One shared port, muxed JTAG > Avalon.
- JTAG commands (mutually exclusive upstream; if coincident, priority b > a > no_action):
  - take_action_ocimem_a:
    - MonAReg <= jdo[33:26].
    - If jdo[35]=1, issue RAM read at jdo[33:26]; MonDReg <= q one cycle later.
  - take_no_action_ocimem_a:
    - Issue RAM read at MonAReg; MonDReg <= q next cycle.
    - MonAReg <= MonAReg+1, wrapping 255->0.
  - take_action_ocimem_b:
    - MonDReg <= jdo[34:3].
    - RAM write of jdo[34:3] at MonAReg, all bytes, ignoring debugaccess.
    - MonAReg <= MonAReg+1 (wrap).
  - A JTAG RAM read and its MonDReg update are never dropped. A new strobe in the q-capture cycle queues its own capture on the following cycle.
- Avalon FSM states:
  - IDLE:
    - Stays in IDLE if there is no request (chipselect & (read|write)).
    - Stays in IDLE if any JTAG strobe is present this cycle.
    - Otherwise performs the access and goes to ACCESS:
      - RAM read: address issued.
      - RAM write: byte-enabled, committed only if debugaccess=1, otherwise silently dropped.
      - Register window: reg_write pulses this cycle on a write.
  - ACCESS: readdata <= q (address[8]=0) or reg_readdata (address[8]=1); -> ACK.
  - ACK: -> IDLE.
  - waitrequest = chipselect & (read|write) & (state != ACK). Every access completes with waitrequest low in the third cycle of the request.
  - readdata holds its value until the next read.
  - A write leaves readdata unchanged.
- Reset asserted mid-access returns to IDLE. The transfer is abandoned, and waitrequest re-asserts while the request is held.

Optional Feature:
OCIMEM_PARITY_EN
- Defined:
  - RAM is 36 bits wide; one even-parity bit per byte is written with the data.
  - Every RAM read checks parity. Any mismatch sets parity_err, which is sticky until reset.
  - Data is still returned unmodified.
- Undefined: RAM is 32 bits wide; parity_err tied 0.

Decomposition:
- Package sdr_msoc_cpu_debug_ocimem_pkg:
  - Avalon FSM state enum (IDLE/ACCESS/ACK).
  - jdo field constants: JDO_ADDR_HI=33, JDO_ADDR_LO=26, JDO_RDEN=35, JDO_DATA_HI=34, JDO_DATA_LO=3.
  - RAM_DEPTH.
- Sub-module sdr_msoc_cpu_debug_ocimem_ram: single-port synchronous RAM with byte enables and optional parity bits.

Test Plan:
- JTAG write then readback: take_action_ocimem_a jdo[33:26]=0x10, jdo[35]=0 -> take_action_ocimem_b data 0xDEADBEEF -> take_action_ocimem_a addr 0x10, rden=1 -> MonDReg=0xDEADBEEF one cycle after the read strobe; MonAReg=0x10.
- Stream read with wrap: MonAReg=0xFF, two take_no_action_ocimem_a -> MonDReg = RAM[0xFF] then RAM[0x00]; MonAReg=0x01.
- Avalon read latency: read address 0x010 -> waitrequest 1,1,0 over three cycles; readdata=0xDEADBEEF in the ACK cycle.
- Write protection: Avalon write address 0x020, writedata 0x12345678, byteenable 0xF, debugaccess=0, then read -> old contents returned. Repeat with debugaccess=1, byteenable 0x3 -> only the low 16 bits equal 0x5678.
- Conflict and register window: Avalon write to address 0x105 coinciding with take_action_ocimem_b -> JTAG write commits first; reg_write pulses exactly once, one cycle later. An Avalon read of 0x105 returns reg_readdata.
- Parity (OCIMEM_PARITY_EN): force a flipped bit in a RAM word, JTAG read it -> parity_err=1 and stays 1 until reset_n pulses low.
